// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce filter.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    WAIT_LOW    = 2'b11
  } state_t;

  localparam int STABLE_CYCLES_DEF = 16;

endpackage

// File: rtl/debounce_filter_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to RST_VAL so the downstream filter sees no false edge out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift din through two flops; synchronous reset to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_filter.sv
// Single-bit debounce / glitch filter with one-cycle rise and fall strobes.
// A level change is accepted only after STABLE_CYCLES consecutive samples of the new value.
// Build option: define DEBOUNCE_SYNC_EN to insert a two-flop synchronizer ahead of the FSM
// (adds two cycles to every latency). Without it, din must already be synchronous to clk.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// STABLE_LOW  | dout=0, input agrees, counter idle
// WAIT_HIGH   | input went high, counting consecutive 1 samples
// STABLE_HIGH | dout=1, input agrees, counter idle
// WAIT_LOW    | input went low, counting consecutive 0 samples
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  // Counter width is derived from STABLE_CYCLES and deliberately not overridable.
  localparam int               CNT_W     = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam state_t           RST_STATE = RST_VAL ? STABLE_HIGH : STABLE_LOW;

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535) begin : g_bad_stable_cycles
    $error("debounce_filter: STABLE_CYCLES=%0d outside legal range 2..65535", STABLE_CYCLES);
  end

  logic sample;

`ifdef DEBOUNCE_SYNC_EN
  sync_2ff #(.RST_VAL(RST_VAL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (sample)
  );
`else
  assign sample = din;
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             dout_n, rise_n, fall_n, busy_n;

  // State, counter and all outputs are registered; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_STATE;
      cnt   <= '0;
      dout  <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dout  <= dout_n;
      rise  <= rise_n;
      fall  <= fall_n;
      busy  <= busy_n;
    end
  end

  // Next-state, counter and output decode; strobes default low so they last one cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dout_n  = dout;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    busy_n  = busy;

    case (state)
      STABLE_LOW: begin
        cnt_n  = '0;
        busy_n = 1'b0;
        if (sample) begin
          state_n = WAIT_HIGH;
          cnt_n   = CNT_ONE;
          busy_n  = 1'b1;
        end
      end

      WAIT_HIGH: begin
        if (!sample) begin
          state_n = STABLE_LOW;
          cnt_n   = '0;
          busy_n  = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_n = STABLE_HIGH;
          cnt_n   = '0;
          dout_n  = 1'b1;
          rise_n  = 1'b1;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      STABLE_HIGH: begin
        cnt_n  = '0;
        busy_n = 1'b0;
        if (!sample) begin
          state_n = WAIT_LOW;
          cnt_n   = CNT_ONE;
          busy_n  = 1'b1;
        end
      end

      WAIT_LOW: begin
        if (sample) begin
          state_n = STABLE_HIGH;
          cnt_n   = '0;
          busy_n  = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_n = STABLE_LOW;
          cnt_n   = '0;
          dout_n  = 1'b0;
          fall_n  = 1'b1;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      // Corrupted encoding: fall back to the stable state that matches the output.
      default: begin
        state_n = dout ? STABLE_HIGH : STABLE_LOW;
        cnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_debounce_filter.sv
// Scoreboard bench for debounce_filter (STABLE_CYCLES=4, RST_VAL=0).
// Expected {dout,rise,fall,busy} is computed from a run-length model of the input
// at drive time, queued, and compared once the DUT has registered that edge.
module tb_debounce_filter;

  localparam int   N  = 4;
  localparam logic RV = 1'b0;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic dout;
    logic rise;
    logic fall;
    logic busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout, rise, fall, busy;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t sb_q[$];

  // Reference model: current accepted level, length of the run of samples that
  // disagree with it, and a delay line standing in for the optional synchronizer.
  logic m_level = RV;
  int   m_run   = 0;
  logic m_p1    = RV;
  logic m_p2    = RV;

  debounce_filter #(.STABLE_CYCLES(N), .RST_VAL(RV)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, push the model's prediction, settle past the edge.
  task automatic step(input logic r, input logic d);
    exp_t e;
    logic s;
    rst = r;
    din = d;
    @(posedge clk);
    e = '0;
    if (r) begin
      m_level = RV;
      m_run   = 0;
      m_p1    = RV;
      m_p2    = RV;
    end else begin
      if (LAT == 2) begin
        s    = m_p2;
        m_p2 = m_p1;
        m_p1 = d;
      end else begin
        s = d;
      end
      if (s != m_level) begin
        m_run = m_run + 1;
        if (m_run == N) begin
          m_level = s;
          m_run   = 0;
          e.rise  = s;
          e.fall  = ~s;
        end
      end else begin
        m_run = 0;
      end
    end
    e.dout = m_level;
    e.busy = (m_run != 0);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    int rises, rise_at;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1);
      e = sb_q.pop_front();
      n_checks++;
      if ({dout, rise, fall, busy} !== e) $display("FAIL reset cyc%0d: got %b exp %b", i, {dout, rise, fall, busy}, e);
      else n_pass++;
    end
    n_checks++;
    if ({dout, rise, fall, busy} !== 4'b0000) $display("FAIL reset_values: got %b exp 0000", {dout, rise, fall, busy});
    else n_pass++;
    rises = 0; rise_at = -1;
    for (int i = 0; i < N + LAT + 3; i++) begin
      step(1'b0, 1'b1);
      e = sb_q.pop_front();
      if (rise) begin rises++; rise_at = i; end
      n_checks++;
      if ({dout, rise, fall, busy} !== e) $display("FAIL clean_rise cyc%0d: got %b exp %b", i, {dout, rise, fall, busy}, e);
      else n_pass++;
    end
    n_checks++;
    if (rises !== 1 || rise_at !== N - 1 + LAT) $display("FAIL rise_timing: got %0d rises at edge %0d exp 1 at %0d", rises, rise_at, N - 1 + LAT);
    else n_pass++;
  endtask

  task automatic test_clean_fall();
    exp_t e;
    int falls, fall_at;
    falls = 0; fall_at = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      e = sb_q.pop_front();
      if (fall) begin falls++; fall_at = i; end
      n_checks++;
      if ({dout, rise, fall, busy} !== e) $display("FAIL clean_fall cyc%0d: got %b exp %b", i, {dout, rise, fall, busy}, e);
      else n_pass++;
    end
    n_checks++;
    if (falls !== 1 || fall_at !== N - 1 + LAT || dout !== 1'b0)
      $display("FAIL fall_timing: got %0d falls at edge %0d dout %b exp 1 at %0d dout 0", falls, fall_at, dout, N - 1 + LAT);
    else n_pass++;
  endtask

  task automatic test_glitch();
    exp_t e;
    logic seq [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int rises;
    rises = 0;
    foreach (seq[i]) begin
      step(1'b0, seq[i]);
      e = sb_q.pop_front();
      if (rise) rises++;
      n_checks++;
      if ({dout, rise, fall, busy} !== e) $display("FAIL glitch cyc%0d: got %b exp %b", i, {dout, rise, fall, busy}, e);
      else n_pass++;
      if (i == 3 + LAT) begin
        n_checks++;
        if (busy !== 1'b0) $display("FAIL glitch_busy_clear: got %b exp 0", busy);
        else n_pass++;
      end
    end
    n_checks++;
    if (rises !== 0 || dout !== 1'b0) $display("FAIL glitch_no_rise: got %0d rises dout %b exp 0 rises dout 0", rises, dout);
    else n_pass++;
  endtask

  task automatic test_bounce();
    exp_t e;
    logic seq [14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int rises, rise_at;
    rises = 0; rise_at = -1;
    foreach (seq[i]) begin
      step(1'b0, seq[i]);
      e = sb_q.pop_front();
      if (rise) begin rises++; rise_at = i; end
      n_checks++;
      if ({dout, rise, fall, busy} !== e) $display("FAIL bounce cyc%0d: got %b exp %b", i, {dout, rise, fall, busy}, e);
      else n_pass++;
    end
    n_checks++;
    if (rises !== 1 || rise_at !== 10 + LAT) $display("FAIL bounce_rise: got %0d rises at %0d exp 1 at %0d", rises, rise_at, 10 + LAT);
    else n_pass++;
    for (int i = 0; i < N + LAT + 1; i++) begin
      step(1'b0, 1'b0);
      e = sb_q.pop_front();
      n_checks++;
      if ({dout, rise, fall, busy} !== e) $display("FAIL bounce_return cyc%0d: got %b exp %b", i, {dout, rise, fall, busy}, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int rises, rise_at;
    for (int i = 0; i < 3; i++) begin
      step(i == 2, 1'b1);
      e = sb_q.pop_front();
      n_checks++;
      if ({dout, rise, fall, busy} !== e) $display("FAIL reset_mid cyc%0d: got %b exp %b", i, {dout, rise, fall, busy}, e);
      else n_pass++;
    end
    n_checks++;
    if ({dout, rise, busy} !== 3'b000) $display("FAIL reset_mid_clear: got %b exp 000", {dout, rise, busy});
    else n_pass++;
    rises = 0; rise_at = -1;
    for (int i = 0; i < N + LAT + 1; i++) begin
      step(1'b0, 1'b1);
      e = sb_q.pop_front();
      if (rise) begin rises++; rise_at = i; end
      n_checks++;
      if ({dout, rise, fall, busy} !== e) $display("FAIL reset_mid_after cyc%0d: got %b exp %b", i, {dout, rise, fall, busy}, e);
      else n_pass++;
    end
    n_checks++;
    if (rises !== 1 || rise_at !== N - 1 + LAT) $display("FAIL reset_mid_requal: got %0d rises at %0d exp 1 at %0d", rises, rise_at, N - 1 + LAT);
    else n_pass++;
  endtask

  task automatic test_final_revert();
    exp_t e;
    logic seq [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int falls;
    falls = 0;
    foreach (seq[i]) begin
      step(1'b0, seq[i]);
      e = sb_q.pop_front();
      if (fall && i < 4 + LAT) falls++;
      n_checks++;
      if ({dout, rise, fall, busy} !== e) $display("FAIL final_revert cyc%0d: got %b exp %b", i, {dout, rise, fall, busy}, e);
      else n_pass++;
    end
    n_checks++;
    if (falls !== 0) $display("FAIL final_revert_no_fall: got %0d falls exp 0", falls);
    else n_pass++;
    for (int i = 0; i < N + LAT; i++) begin
      step(1'b0, 1'b0);
      e = sb_q.pop_front();
      n_checks++;
      if ({dout, rise, fall, busy} !== e) $display("FAIL final_revert_tail cyc%0d: got %b exp %b", i, {dout, rise, fall, busy}, e);
      else n_pass++;
    end
  endtask

  task automatic test_fast_toggle();
    exp_t e;
    int strobes;
    strobes = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, (i % 3) != 2);
      e = sb_q.pop_front();
      if (rise || fall) strobes++;
      n_checks++;
      if ({dout, rise, fall, busy} !== e) $display("FAIL fast_toggle cyc%0d: got %b exp %b", i, {dout, rise, fall, busy}, e);
      else n_pass++;
    end
    n_checks++;
    if (strobes !== 0 || dout !== 1'b0) $display("FAIL fast_toggle_hold: got %0d strobes dout %b exp 0 dout 0", strobes, dout);
    else n_pass++;
  endtask

  task automatic test_random();
    exp_t e;
    logic d;
    int runlen;
    d = 1'b0; runlen = 0;
    for (int i = 0; i < 400; i++) begin
      if (runlen == 0) begin
        d      = ~d;
        runlen = $urandom_range(1, 2 * N + 2);
      end
      runlen--;
      step(($urandom_range(0, 99) == 0), d);
      e = sb_q.pop_front();
      n_checks++;
      if ({dout, rise, fall, busy} !== e) $display("FAIL random cyc%0d: got %b exp %b", i, {dout, rise, fall, busy}, e);
      else n_pass++;
      if (rise && fall) begin
        n_checks++;
        $display("FAIL strobe_exclusive cyc%0d: got rise=1 fall=1 exp not both", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_fall();
    test_glitch();
    test_bounce();
    test_reset_mid();
    step(1'b1, 1'b0);
    void'(sb_q.pop_front());
    test_reset();
    test_final_revert();
    test_fast_toggle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debounce_filter.md
Name: debounce_filter

Overview:
- Single-bit glitch filter placed directly downstream of the DFF stage.
- Consumes the registered bit (the DFF's dout) and produces a stable level that changes only after the input has held a new value for STABLE_CYCLES consecutive clocks.
- Also emits one-cycle rise/fall strobes for downstream control logic (button/switch inputs, slow status lines).

Parameters:
- STABLE_CYCLES, 16: consecutive identical samples required to accept a level change. Legal range 2..65535; elaboration-time assertion otherwise.
- RST_VAL, 1'b0: value of dout after reset. Selects reset state STABLE_LOW (0) or STABLE_HIGH (1).
- CNT_W, $clog2(STABLE_CYCLES+1): counter width. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- din  input  1  raw registered bit from DFF stage
- dout  output  1  debounced level, registered
- rise  output  1  one-cycle pulse when dout goes 0->1, registered
- fall  output  1  one-cycle pulse when dout goes 1->0, registered
- busy  output  1  high while a candidate change is being qualified (WAIT_* states), registered

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - dout=RST_VAL, rise=0, fall=0, busy=0, cnt=0.
  - state=STABLE_LOW if RST_VAL==0, else STABLE_HIGH.
- Reset precedence:
  - rst wins over all other activity.
  - Reset mid-qualification discards the count; no strobe fires on the reset edge.
- FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW. din is sampled at every posedge.
- STABLE_LOW:
  - din=1 -> WAIT_HIGH, cnt<=1, busy<=1.
  - din=0 -> stay.
- WAIT_HIGH:
  - din=0 -> STABLE_LOW, cnt<=0, busy<=0 (glitch rejected, no strobe).
  - din=1 and cnt==STABLE_CYCLES-1 -> STABLE_HIGH, dout<=1, rise<=1, busy<=0, cnt<=0.
  - din=1 otherwise -> cnt<=cnt+1.
- STABLE_HIGH / WAIT_LOW: mirror of the above with polarity inverted; fall strobes instead of rise.
- Latency:
  - dout updates on the edge that registers the STABLE_CYCLES-th consecutive sample of the new value.
  - First sample of a new value on edge k -> dout valid after edge k+STABLE_CYCLES-1.
- Strobe timing:
  - rise/fall are high for exactly one cycle, coincident with the dout change.
  - rise and fall are never high simultaneously.
- Bounce handling:
  - A reversion at any count, including the final sample (cnt==STABLE_CYCLES-1 with din reverted), restarts qualification.
  - Repeated toggling faster than STABLE_CYCLES keeps dout unchanged indefinitely.
- Counter:
  - cnt never exceeds STABLE_CYCLES-1.
  - cnt holds 0 in both STABLE states.
  - No wrap-around is possible.
- Illegal state encoding: recovers to the STABLE state matching current dout, cnt<=0.

Optional Feature:
- Macro: DEBOUNCE_SYNC_EN.
- Defined:
  - din passes through a two-flop synchronizer (reset to RST_VAL) before the FSM.
  - All latencies increase by 2 cycles.
  - Synchronizer flops reset with rst.
- Not defined:
  - din feeds the FSM directly; din must already be synchronous to clk, which the DFF stage guarantees.

Decomposition:
- Package debounce_pkg:
  - state_t enum typedef (STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW).
  - Default STABLE_CYCLES constant.
- Sub-module sync_2ff:
  - Ports clk, rst, d, q; parameter RST_VAL.
  - Instantiated only under DEBOUNCE_SYNC_EN.
- FSM and counter stay in debounce_filter.

Test Plan (STABLE_CYCLES=4, RST_VAL=0, macro undefined unless stated):
- Reset: hold rst 2 cycles with din=1 -> dout=0, rise=fall=busy=0; after release, din held 1 -> dout=1 and rise=1 for one cycle on the 4th sampling edge.
- Glitch: din=1 for 3 cycles, then 0 -> dout stays 0, no rise, busy returns to 0 the cycle after the reversion.
- Clean fall: from dout=1, din=0 held 10 cycles -> fall=1 exactly once, on the 4th edge; dout=0 thereafter.
- Bounce train: din toggles 1,1,0,1,1,1,0,1,1,1,1 -> dout=1 only after the final four 1s; exactly one rise.
- Reset mid-qualification: din=1 for 2 cycles, assert rst at cycle 3 -> cnt cleared, no rise; after release, 4 further 1-samples are needed before dout=1.
- DEBOUNCE_SYNC_EN defined: repeat clean-rise case -> rise occurs 2 cycles later than without the macro, with identical pulse width.
